// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, fixed bitrate from the system
// clock, and an optional idle gap after every stop bit.
module uart_tx #(
    parameter int unsigned CLK_HZ      = 66_000_000,
    parameter int unsigned BITRATE_BPS = 9_600,
    parameter int unsigned GAP_BITS    = 5,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BIT_CLK = CLK_HZ / BITRATE_BPS;
    localparam int unsigned CNT_W   = $clog2(BIT_CLK);
    localparam int unsigned GAP_W   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push_c;
    logic               pop_c;
    logic               bit_done_c;
    logic               fifo_empty_c;

    assign push_c       = data_in_valid && ready_q;
    assign fifo_empty_c = (count_q == '0);
    assign bit_done_c   = (bit_cnt_q == CNT_W'(BIT_CLK - 1));

    // Next-state logic; every pop loads the head byte and restarts the counters.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        pop_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (GAP_BITS != 0) begin
                        state_d = ST_GAP;
                    end else if (!fifo_empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        idx_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    if (gap_cnt_q == GAP_W'(GAP_BITS - 1)) begin
                        gap_cnt_d = '0;
                        if (!fifo_empty_c) begin
                            pop_c   = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            idx_d   = '0;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and registered outputs derived from the next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - LVL_W'(1);
        end

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE) || (count_d != '0);
        ready_d = (count_d != LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx            = tx_q;
    assign busy          = busy_q;
    assign data_in_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line decoder acts as the receiver and checks bytes
// against a scoreboard queue, plus waveform, spacing, reset and full checks.
module tb_uart_tx;

    localparam int BITC  = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy;
    logic [7:0] data_in0 = 8'h00;
    logic       valid0 = 1'b0;
    logic       ready0, tx0, busy0;

    uart_tx #(.CLK_HZ(1000), .BITRATE_BPS(100), .GAP_BITS(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(valid),
        .data_in_ready(ready), .tx(tx), .busy(busy)
    );

    uart_tx #(.CLK_HZ(1000), .BITRATE_BPS(100), .GAP_BITS(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in0), .data_in_valid(valid0),
        .data_in_ready(ready0), .tx(tx0), .busy(busy0)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         starts0[$];
    int         starts1[$];
    int         frames0 = 0;
    int         frames1 = 0;
    bit         acc0 = 1'b0;
    int         mcount = 0;

    bit         act_l[2];
    bit         prev_l[2];
    int         t0_l[2];
    logic [7:0] sh_l[2];

    initial begin
        for (int l = 0; l < 2; l++) begin
            act_l[l]  = 1'b0;
            prev_l[l] = 1'b1;
            t0_l[l]   = 0;
            sh_l[l]   = 8'h00;
        end
    end

    // Receiver model: find the start edge, sample mid-bit, check the stop bit.
    always @(negedge clk) begin
        logic [1:0] line;
        bit         started;
        int         k;
        line    = {tx0, tx};
        started = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (!rst_at_edge) begin
                act_l[l] = 1'b0;
            end else if (!act_l[l]) begin
                if (prev_l[l] && !line[l]) begin
                    act_l[l] = 1'b1;
                    t0_l[l]  = cyc;
                    if (l == 0) begin
                        starts0.push_back(cyc);
                        started = 1'b1;
                    end else begin
                        starts1.push_back(cyc);
                    end
                end
            end else begin
                k = cyc - t0_l[l];
                if (k == BITC / 2) begin
                    check("start_bit", int'(line[l]), 0);
                end else if (k >= BITC + BITC / 2 && k < 9 * BITC && (k % BITC) == BITC / 2) begin
                    sh_l[l] = {line[l], sh_l[l][7:1]};
                end else if (k == 9 * BITC + BITC / 2) begin
                    check("stop_bit", int'(line[l]), 1);
                    act_l[l] = 1'b0;
                    if (l == 0) begin
                        frames0++;
                        if (exp_q0.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_byte0: got %02h, expected none", sh_l[l]);
                        end else begin
                            check("rx_byte0", int'(sh_l[l]), int'(exp_q0.pop_front()));
                        end
                    end else begin
                        frames1++;
                        if (exp_q1.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_byte1: got %02h, expected none", sh_l[l]);
                        end else begin
                            check("rx_byte1", int'(sh_l[l]), int'(exp_q1.pop_front()));
                        end
                    end
                end
            end
            prev_l[l] = rst_at_edge ? line[l] : 1'b1;
        end
        // Occupancy model: accepts add, observed start bits remove.
        if (!rst_at_edge) begin
            mcount = 0;
        end else begin
            mcount = mcount + (acc0 ? 1 : 0) - (started ? 1 : 0);
            check("ready_vs_level", int'(ready), (mcount < DEPTH) ? 1 : 0);
        end
        acc0 = 1'b0;
    end

    // Presents a byte and holds valid high until it is accepted.
    task automatic push(input int ln, input logic [7:0] b, output int acc_cyc);
        int  budget;
        bit  done;
        logic r;
        budget  = 3000;
        done    = 1'b0;
        acc_cyc = -1;
        while (!done && budget > 0) begin
            @(negedge clk);
            if (ln == 0) begin
                data_in = b; valid = 1'b1; r = ready;
            end else begin
                data_in0 = b; valid0 = 1'b1; r = ready0;
            end
            if (r) acc_cyc = cyc + 1;
            @(posedge clk);
            if (r) begin
                done = 1'b1;
                if (ln == 0) begin
                    exp_q0.push_back(b);
                    acc0 = 1'b1;
                end else begin
                    exp_q1.push_back(b);
                end
            end
            budget--;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: got no accept, expected accept of %02h", b);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        valid  = 1'b0;
        valid0 = 1'b0;
    endtask

    task automatic wait_drain(input int ln);
        int budget;
        budget = 6000;
        while (budget > 0 && ((ln == 0) ? (busy || exp_q0.size() != 0)
                                        : (busy0 || exp_q1.size() != 0))) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got busy after budget, expected idle (line %0d)", ln);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, e, f0, s0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(ready), 1);
        check("idle_tx", int'(tx), 1);

        // Exact waveform of a single 0xA5 frame
        b = 8'hA5;
        push(0, b, n);
        release_valid();
        c = 0;
        while (c < 160) begin
            if (cyc - n >= c) begin
                if (c >= 1 && c <= 10)       e = 0;
                else if (c >= 11 && c <= 90) e = int'(b[(c - 11) / 10]);
                else                         e = 1;
                check("a5_tx", int'(tx), e);
                check("a5_busy", int'(busy), (c < 151) ? 1 : 0);
                c++;
            end else begin
                @(negedge clk);
            end
        end
        check("a5_frames", frames0, 1);

        // Loopback of three bytes
        f0 = frames0;
        push(0, 8'h00, n);
        push(0, 8'hFF, n);
        push(0, 8'h3C, n);
        release_valid();
        wait_drain(0);
        check("loop_frames", frames0 - f0, 3);

        // Burst of six with valid held high; starts 150 cycles apart
        f0 = frames0;
        s0 = starts0.size();
        for (int i = 0; i < 6; i++) push(0, 8'($urandom), n);
        release_valid();
        wait_drain(0);
        check("burst_frames", frames0 - f0, 6);
        for (int i = s0 + 1; i < s0 + 6 && i < starts0.size(); i++)
            check("burst_spacing", starts0[i] - starts0[i - 1], 150);

        // Random bytes with random idle periods
        f0 = frames0;
        for (int i = 0; i < 16; i++) begin
            push(0, 8'($urandom), n);
            if ($urandom_range(0, 2) == 0) begin
                release_valid();
                repeat ($urandom_range(1, 200)) @(negedge clk);
            end
        end
        release_valid();
        wait_drain(0);
        check("rand_frames", frames0 - f0, 16);

        // No gap: back-to-back start bits 100 cycles apart
        push(1, 8'hC3, n);
        push(1, 8'h5A, n);
        release_valid();
        wait_drain(1);
        check("nogap_frames", frames1, 2);
        if (starts1.size() >= 2) check("nogap_spacing", starts1[1] - starts1[0], 100);
        else check("nogap_starts", starts1.size(), 2);

        // Reset 45 cycles into a 0x55 frame with two bytes queued
        s0 = starts0.size();
        push(0, 8'h55, n);
        push(0, 8'h11, n);
        push(0, 8'h22, n);
        release_valid();
        c = 0;
        while (starts0.size() == s0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("rst_frame_started", starts0.size(), s0 + 1);
        while (cyc < starts0[$] + 44) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(ready), 0);
        rst_n = 1'b1;
        exp_q0.delete();
        f0 = frames0;
        s0 = starts0.size();
        @(negedge clk);
        check("midrst_ready_rel", int'(ready), 1);
        repeat (400) @(negedge clk);
        check("midrst_no_frames", frames0 - f0, 0);
        check("midrst_no_starts", starts0.size() - s0, 0);
        check("midrst_busy_after", int'(busy), 0);

        // Full FIFO: 0x77 offered while not ready must not be taken
        f0 = frames0;
        for (int i = 0; i < 5; i++) push(0, 8'(8'h80 + i), n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_in = 8'h77;
            valid   = 1'b1;
            check("full_ready_low", int'(ready), 0);
            @(posedge clk);
        end
        release_valid();
        push(0, 8'h77, n);
        release_valid();
        wait_drain(0);
        check("full_frames", frames0 - f0, 6);

        check("sb0_empty", exp_q0.size(), 0);
        check("sb1_empty", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
